// File: rtl/lcd_nibble_controller_pkg.sv
// Shared encodings, default timing constants and the counter-load helper
// for the LCD nibble endpoint.
package lcd_nibble_controller_pkg;
    localparam int CNT_W = 20;

    // Top FSM encodings
    localparam logic [2:0] ST_INIT_WAIT = 3'd0;
    localparam logic [2:0] ST_INIT_W1   = 3'd1;
    localparam logic [2:0] ST_INIT_W2   = 3'd2;
    localparam logic [2:0] ST_INIT_W3   = 3'd3;
    localparam logic [2:0] ST_INIT_W4   = 3'd4;
    localparam logic [2:0] ST_IDLE      = 3'd5;
    localparam logic [2:0] ST_WRITE     = 3'd6;

    // Write sub-sequence encodings
    localparam logic [2:0] SUB_IDLE  = 3'd0;
    localparam logic [2:0] SUB_SETUP = 3'd1;
    localparam logic [2:0] SUB_PULSE = 3'd2;
    localparam logic [2:0] SUB_HOLD  = 3'd3;
    localparam logic [2:0] SUB_GAP   = 3'd4;

    // Trailing-gap selectors
    localparam logic [1:0] GAP_LONG   = 2'd0;
    localparam logic [1:0] GAP_SHORT  = 2'd1;
    localparam logic [1:0] GAP_BYTE   = 2'd2;
    localparam logic [1:0] GAP_NIBBLE = 2'd3;

    // Default cycle counts at 50 MHz
    localparam int DEF_T_POWERUP    = 750000;
    localparam int DEF_T_INIT_LONG  = 205000;
    localparam int DEF_T_INIT_SHORT = 5000;
    localparam int DEF_T_SETUP      = 2;
    localparam int DEF_T_PULSE      = 12;
    localparam int DEF_T_HOLD       = 1;
    localparam int DEF_T_NIBBLE_GAP = 50;
    localparam int DEF_T_BYTE_GAP   = 2000;

    // A phase lasting N cycles loads N-1; the phase ends on the cycle the count is 0.
    function automatic logic [CNT_W-1:0] cntLoad(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction
endpackage

// File: rtl/lcd_nibble_controller_pulse_timer.sv
// SETUP/PULSE/HOLD/GAP sequencer around the single shared down-counter.
// Out of reset it sits in GAP loaded with the power-up wait, so the top's
// INIT_WAIT is timed by the same counter and ends on the first 'done'.
module lcd_pulse_timer
    import lcd_nibble_controller_pkg::*;
#(
    parameter int T_POWERUP    = DEF_T_POWERUP,
    parameter int T_INIT_LONG  = DEF_T_INIT_LONG,
    parameter int T_INIT_SHORT = DEF_T_INIT_SHORT,
    parameter int T_SETUP      = DEF_T_SETUP,
    parameter int T_PULSE      = DEF_T_PULSE,
    parameter int T_HOLD       = DEF_T_HOLD,
    parameter int T_NIBBLE_GAP = DEF_T_NIBBLE_GAP,
    parameter int T_BYTE_GAP   = DEF_T_BYTE_GAP
) (
    input  logic       gclk,
    input  logic       grst_n,
    input  logic       start,
    input  logic [1:0] gapSel,
    output logic       lcdE,
    output logic       done
);
    logic [2:0]       subState;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] gapLoad;
    logic [CNT_W-1:0] selLoad;

    // Gap length for the write being started
    always_comb begin
        selLoad = cntLoad(T_BYTE_GAP);
        case (gapSel)
            GAP_LONG:   selLoad = cntLoad(T_INIT_LONG);
            GAP_SHORT:  selLoad = cntLoad(T_INIT_SHORT);
            GAP_BYTE:   selLoad = cntLoad(T_BYTE_GAP);
            GAP_NIBBLE: selLoad = cntLoad(T_NIBBLE_GAP);
        endcase
    end

    assign done = (subState == SUB_GAP) && (cnt == '0);

    // Sub-state sequencing; start takes priority so back-to-back writes chain with no idle cycle
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            subState <= SUB_GAP;
            cnt      <= cntLoad(T_POWERUP);
            gapLoad  <= '0;
            lcdE     <= 1'b0;
        end else if (start) begin
            subState <= SUB_SETUP;
            cnt      <= cntLoad(T_SETUP);
            gapLoad  <= selLoad;
            lcdE     <= 1'b0;
        end else if (subState != SUB_IDLE) begin
            if (cnt != '0) begin
                cnt <= cnt - 20'd1;
            end else begin
                case (subState)
                    SUB_SETUP: begin
                        subState <= SUB_PULSE;
                        cnt      <= cntLoad(T_PULSE);
                        lcdE     <= 1'b1;
                    end
                    SUB_PULSE: begin
                        subState <= SUB_HOLD;
                        cnt      <= cntLoad(T_HOLD);
                        lcdE     <= 1'b0;
                    end
                    SUB_HOLD: begin
                        subState <= SUB_GAP;
                        cnt      <= gapLoad;
                    end
                    default: begin
                        subState <= SUB_IDLE;
                        lcdE     <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: rtl/lcd_nibble_controller.sv
// LCD endpoint of the MiniAlu nibble interface: runs HD44780 4-bit power-up
// init, then forwards ALU nibbles with edge-detected strobes and busy reporting.
module lcd_nibble_controller
    import lcd_nibble_controller_pkg::*;
#(
    parameter int T_POWERUP    = DEF_T_POWERUP,
    parameter int T_INIT_LONG  = DEF_T_INIT_LONG,
    parameter int T_INIT_SHORT = DEF_T_INIT_SHORT,
    parameter int T_SETUP      = DEF_T_SETUP,
    parameter int T_PULSE      = DEF_T_PULSE,
    parameter int T_HOLD       = DEF_T_HOLD,
    parameter int T_NIBBLE_GAP = DEF_T_NIBBLE_GAP,
    parameter int T_BYTE_GAP   = DEF_T_BYTE_GAP
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] iLCD_data,
    input  logic       iLCD_rs,
    input  logic       iLCD_writeEN,
    output logic       oLCD_response,
    output logic [3:0] oLCD_D,
    output logic       oLCD_E,
    output logic       oLCD_RS,
    output logic       oLCD_RW
);
    logic [2:0] state;
    logic       phaseLow;
    logic       wePrev;
    logic       accept;
    logic       timerStart;
    logic [1:0] gapSel;
    logic       timerDone;

    assign oLCD_RW = 1'b0;

    lcd_pulse_timer #(
        .T_POWERUP   (T_POWERUP),
        .T_INIT_LONG (T_INIT_LONG),
        .T_INIT_SHORT(T_INIT_SHORT),
        .T_SETUP     (T_SETUP),
        .T_PULSE     (T_PULSE),
        .T_HOLD      (T_HOLD),
        .T_NIBBLE_GAP(T_NIBBLE_GAP),
        .T_BYTE_GAP  (T_BYTE_GAP)
    ) uTimer (
        .gclk  (Clock),
        .grst_n(Reset),
        .start (timerStart),
        .gapSel(gapSel),
        .lcdE  (oLCD_E),
        .done  (timerDone)
    );

    // Start the next write and pick its trailing gap; the gap belongs to the state being entered
    always_comb begin
        accept     = (state == ST_IDLE) && iLCD_writeEN && !wePrev;
        timerStart = 1'b0;
        gapSel     = GAP_BYTE;
        case (state)
            ST_INIT_WAIT: begin timerStart = timerDone; gapSel = GAP_LONG;  end
            ST_INIT_W1:   begin timerStart = timerDone; gapSel = GAP_SHORT; end
            ST_INIT_W2:   begin timerStart = timerDone; gapSel = GAP_BYTE;  end
            ST_INIT_W3:   begin timerStart = timerDone; gapSel = GAP_BYTE;  end
            ST_IDLE: begin
                timerStart = accept;
                gapSel     = phaseLow ? GAP_BYTE : GAP_NIBBLE;
            end
            default: ;
        endcase
    end

    // Init sequencing, strobe edge detect, nibble phase and busy flag
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state         <= ST_INIT_WAIT;
            oLCD_response <= 1'b1;
            oLCD_D        <= 4'h0;
            oLCD_RS       <= 1'b0;
            phaseLow      <= 1'b0;
            wePrev        <= 1'b1;
        end else begin
            wePrev <= iLCD_writeEN;
            case (state)
                ST_INIT_WAIT: if (timerDone) begin state <= ST_INIT_W1; oLCD_D <= 4'h3; oLCD_RS <= 1'b0; end
                ST_INIT_W1:   if (timerDone) begin state <= ST_INIT_W2; oLCD_D <= 4'h3; end
                ST_INIT_W2:   if (timerDone) begin state <= ST_INIT_W3; oLCD_D <= 4'h3; end
                ST_INIT_W3:   if (timerDone) begin state <= ST_INIT_W4; oLCD_D <= 4'h2; end
                ST_INIT_W4: if (timerDone) begin
                    state         <= ST_IDLE;
                    oLCD_response <= 1'b0;
                    phaseLow      <= 1'b0;
                end
                ST_IDLE: if (accept) begin
                    state         <= ST_WRITE;
                    oLCD_response <= 1'b1;
                    oLCD_D        <= iLCD_data;
                    oLCD_RS       <= iLCD_rs;
                end
                ST_WRITE: if (timerDone) begin
                    state         <= ST_IDLE;
                    oLCD_response <= 1'b0;
                    phaseLow      <= ~phaseLow;
                end
                default: state <= ST_INIT_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_nibble_controller.sv
// Directed bench for lcd_nibble_controller with shortened timing.
module tb_lcd_nibble_controller;
    localparam int T_POWERUP = 20, T_INIT_LONG = 10, T_INIT_SHORT = 5, T_BYTE_GAP = 8;
    localparam int T_NIBBLE_GAP = 3, T_SETUP = 2, T_PULSE = 4, T_HOLD = 1;
    localparam int INIT_IDLE_EDGE = 79;   // 20 + 4*7 + 10 + 5 + 2*8
    localparam int BUSY_HI = 10;          // 2+4+1+3
    localparam int BUSY_LO = 15;          // 2+4+1+8

    logic       clk = 1'b0;
    logic       Reset = 1'b0;
    logic [3:0] iLCD_data = 4'h0;
    logic       iLCD_rs = 1'b0;
    logic       iLCD_writeEN = 1'b0;
    logic       oLCD_response, oLCD_E, oLCD_RS, oLCD_RW;
    logic [3:0] oLCD_D;

    always #5 clk = ~clk;

    lcd_nibble_controller #(
        .T_POWERUP(T_POWERUP), .T_INIT_LONG(T_INIT_LONG), .T_INIT_SHORT(T_INIT_SHORT),
        .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD),
        .T_NIBBLE_GAP(T_NIBBLE_GAP), .T_BYTE_GAP(T_BYTE_GAP)
    ) dut (
        .Clock(clk), .Reset(Reset), .iLCD_data(iLCD_data), .iLCD_rs(iLCD_rs),
        .iLCD_writeEN(iLCD_writeEN), .oLCD_response(oLCD_response), .oLCD_D(oLCD_D),
        .oLCD_E(oLCD_E), .oLCD_RS(oLCD_RS), .oLCD_RW(oLCD_RW)
    );

    // Bus monitor: logs each E pulse, its width, D/RS stability and busy run lengths
    int         busyRun = 0, lastBusy = 0, lastRise = 0, eRun = 0;
    int         stabErr = 0, rwErr = 0;
    logic       prevE = 1'b0, capRs = 1'b0;
    logic [3:0] capD = 4'h0;
    int         pD[$];
    int         pRS[$];

    always @(negedge clk) begin
        if (oLCD_RW !== 1'b0) rwErr++;
        if (oLCD_response === 1'b1) busyRun++;
        else begin
            if (busyRun > 0) lastBusy = busyRun;
            busyRun = 0;
        end
        if (oLCD_E === 1'b1) begin
            if (!prevE) begin
                pD.push_back(int'(oLCD_D));
                pRS.push_back(int'(oLCD_RS));
                capD = oLCD_D; capRs = oLCD_RS;
                lastRise = busyRun;
                eRun = 1;
            end else begin
                eRun++;
                if (oLCD_D !== capD || oLCD_RS !== capRs) stabErr++;
            end
        end else if (prevE && Reset) begin
            if (oLCD_D !== capD || oLCD_RS !== capRs) stabErr++;
            if (eRun != T_PULSE) stabErr++;
        end
        prevE = oLCD_E;
    end

    int nChk = 0, nPass = 0;

    task automatic check(input string name, input int act, input int exp);
        nChk++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic strobe(input logic [3:0] d, input logic r);
        iLCD_data = d; iLCD_rs = r; iLCD_writeEN = 1'b1;
        tick;
        iLCD_writeEN = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        for (int k = 0; k < 100; k++) begin
            if (oLCD_response === 1'b0) break;
            tick;
        end
        check({tag, "_idle"}, int'(oLCD_response), 0);
    endtask

    // Release reset and follow the autonomous init, optionally poking a strobe mid-way
    task automatic runInit(input string tag, input bit poke);
        int n, base;
        int initD[4];
        initD = '{3, 3, 3, 2};
        base = pD.size();
        Reset = 1'b1;
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            tick;
            n = i;
            if (poke && i == 30) iLCD_writeEN = 1'b1;
            if (poke && i == 32) iLCD_writeEN = 1'b0;
            if (oLCD_response === 1'b0) break;
        end
        check({tag, "_idle_edge"}, n, INIT_IDLE_EDGE);
        check({tag, "_pulses"}, pD.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < pD.size()) begin
                check($sformatf("%s_D%0d", tag, i), pD[base+i], initD[i]);
                check($sformatf("%s_RS%0d", tag, i), pRS[base+i], 0);
            end
        end
    endtask

    typedef struct {
        logic [3:0] data;
        logic       rs;
        int         expD;
        int         expRs;
        int         expBusy;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int base;
        vecs[0] = '{4'h4, 1'b1, 4,  1, BUSY_HI};
        vecs[1] = '{4'h1, 1'b1, 1,  1, BUSY_LO};
        vecs[2] = '{4'hA, 1'b0, 10, 0, BUSY_HI};
        vecs[3] = '{4'h5, 1'b0, 5,  0, BUSY_LO};
        vecs[4] = '{4'hF, 1'b1, 15, 1, BUSY_HI};
        vecs[5] = '{4'h0, 1'b0, 0,  0, BUSY_LO};

        // Reset state
        tick; tick;
        check("rst_response", int'(oLCD_response), 1);
        check("rst_E", int'(oLCD_E), 0);
        check("rst_RS", int'(oLCD_RS), 0);
        check("rst_RW", int'(oLCD_RW), 0);
        check("rst_D", int'(oLCD_D), 0);

        // Init with a strobe edge during it, which must be ignored
        runInit("init", 1'b1);

        // Table of user writes; phase alternates HIGH/LOW regardless of RS
        for (int v = 0; v < 6; v++) begin
            base = pD.size();
            strobe(vecs[v].data, vecs[v].rs);
            waitIdle($sformatf("vec%0d", v));
            check($sformatf("vec%0d_pulses", v), pD.size() - base, 1);
            if (pD.size() > base) begin
                check($sformatf("vec%0d_D", v), pD[base], vecs[v].expD);
                check($sformatf("vec%0d_RS", v), pRS[base], vecs[v].expRs);
            end
            check($sformatf("vec%0d_busy", v), lastBusy, vecs[v].expBusy);
            check($sformatf("vec%0d_setup", v), lastRise, T_SETUP + 1);
        end

        // Strobe held high: one write only, then a fresh edge is needed
        base = pD.size();
        iLCD_data = 4'h6; iLCD_rs = 1'b0; iLCD_writeEN = 1'b1;
        tick;
        waitIdle("held");
        repeat (30) tick;
        check("held_pulses", pD.size() - base, 1);
        check("held_no_reaccept", int'(oLCD_response), 0);
        check("held_busy", lastBusy, BUSY_HI);
        iLCD_writeEN = 1'b0;
        tick;
        strobe(4'h9, 1'b1);
        waitIdle("rearm");
        check("rearm_pulses", pD.size() - base, 2);
        check("rearm_busy", lastBusy, BUSY_LO);

        // Strobe edge during GAP: ignored and not queued
        base = pD.size();
        strobe(4'h7, 1'b1);
        repeat (6) tick;               // now in HOLD; next edge enters GAP
        iLCD_writeEN = 1'b1;
        tick;
        iLCD_writeEN = 1'b0;
        waitIdle("gap");
        repeat (5) tick;
        check("gap_pulses", pD.size() - base, 1);
        check("gap_no_queue", int'(oLCD_response), 0);
        check("gap_busy", lastBusy, BUSY_HI);

        // Reset mid-PULSE: E must drop with no clock edge
        strobe(4'hC, 1'b1);
        for (int k = 0; k < 20; k++) begin
            if (oLCD_E === 1'b1) break;
            tick;
        end
        check("midpulse_E_high", int'(oLCD_E), 1);
        #2 Reset = 1'b0;
        #1;
        check("async_E", int'(oLCD_E), 0);
        check("async_response", int'(oLCD_response), 1);
        check("async_D", int'(oLCD_D), 0);
        tick; tick;
        runInit("reinit", 1'b0);

        check("D_RS_stable", stabErr, 0);
        check("RW_zero", rwErr, 0);

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end
endmodule
